// File: rtl/icache_req_responder_pkg.sv
// icache_req_responder_pkg
//   Shared definitions for the I-Cache request responder.
//   The responder FSM state encoding, line geometry and default widths
//   live here.
//   Contents:
//     icr_state_t     responder FSM states (exposed on dbg_state)
//     DEF_INDEX_W     default set-index width
//     OFFSET_W        byte-offset bits inside one 16-byte line
//     WORD_W, LINE_W  instruction word and line widths
//     BEAT_W          width of the refill beat counter
//     ZERO_WORD       all-zero instruction word
package icache_req_responder_pkg;

  localparam int DEF_INDEX_W = 8;
  localparam int OFFSET_W    = 4;
  localparam int WORD_W      = 32;
  localparam int LINE_W      = 128;
  localparam int BEAT_W      = 2;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    ICR_IDLE     = 3'd0,
    ICR_LOOKUP   = 3'd1,
    ICR_MISS_REQ = 3'd2,
    ICR_REFILL   = 3'd3,
    ICR_RESP     = 3'd4
  } icr_state_t;

endpackage

// File: rtl/icache_req_responder_line_store.sv
// icache_line_store
//   Direct-mapped line storage: tag, valid and data arrays with one
//   synchronous read port and one write port. Valid bits are cleared
//   asynchronously by reset; tag and data arrays carry no reset.
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-low reset (clears valid bits)
//     rd_en     in   capture the set at rd_index on the next edge
//     rd_index  in   set to read
//     wr_en     in   write tag/data of wr_index and mark it valid
//     wr_index  in   set to write
//     wr_tag    in   tag to store
//     wr_data   in   line to store
//     rd_valid  out  registered valid bit of the last read set
//     rd_tag    out  registered tag of the last read set
//     rd_data   out  registered line of the last read set
module icache_line_store
  import icache_req_responder_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = 32 - DEF_INDEX_W - OFFSET_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  // The valid bit of the read port is reset so a read captured before reset
  // can never produce a hit afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= valid_q[rd_index];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_index];
      rd_data <= data_mem[rd_index];
    end
  end

endmodule

// File: rtl/icache_req_responder.sv
// icache_req_responder
//   Responder end of the sram-like I-Cache fetch bus. Accepts a 16-byte
//   aligned fetch index, looks the line up one cycle later with the MMU tag,
//   and returns the 4-word line. Misses and uncached accesses run a 4-beat
//   burst refill from memory.
//
//   Handshakes:
//     inst_req/inst_index_ok : a request transfers in a cycle where both are 1.
//     mem_rd_req/mem_rd_ready: the burst request transfers in a cycle where
//                              both are 1; mem_rd_req and mem_rd_addr stay
//                              stable until then.
//     mem_rd_valid           : one beat per cycle where it is 1; no backpressure.
//
//   Optional feature: define ICACHE_PERF_CNT_EN to add perf_access_o and
//   perf_miss_o wrap-around counters.
//
//   Ports:
//     clk, rst          clock / asynchronous active-low reset
//     inst_req          fetch request valid
//     inst_wr           ignored (read only)
//     inst_size         ignored (always served as 4 words)
//     inst_index        set index of the request
//     inst_wdata        ignored
//     inst_index_ok     request accepted when inst_req is also 1
//     inst_ptag_i       physical tag, valid in the LOOKUP cycle
//     inst_uncached_i   uncached attribute, valid in the LOOKUP cycle
//     inst_cancel_i     flush: drop the in-flight response
//     inst_rdata        4 words, word0 in [31:0]
//     inst_data_ok      inst_rdata valid, single-cycle pulse
//     mem_rd_req        burst read request
//     mem_rd_addr       {ptag, index, 4'b0}
//     mem_rd_ready      burst request accepted
//     mem_rd_valid      read beat valid
//     mem_rd_data       read beat data, ascending word order
//     mem_rd_last       final beat
//     perf_access_o     (ICACHE_PERF_CNT_EN) accepted requests
//     perf_miss_o       (ICACHE_PERF_CNT_EN) LOOKUP misses incl. uncached
//     dbg_state         current FSM state (icr_state_t encoding)
module icache_req_responder
  import icache_req_responder_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = 32 - INDEX_W - OFFSET_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_req,
  input  logic               inst_wr,
  input  logic [1:0]         inst_size,
  input  logic [INDEX_W-1:0] inst_index,
  input  logic [31:0]        inst_wdata,
  output logic               inst_index_ok,
  input  logic [TAG_W-1:0]   inst_ptag_i,
  input  logic               inst_uncached_i,
  input  logic               inst_cancel_i,
  output logic [LINE_W-1:0]  inst_rdata,
  output logic               inst_data_ok,
  output logic               mem_rd_req,
  output logic [31:0]        mem_rd_addr,
  input  logic               mem_rd_ready,
  input  logic               mem_rd_valid,
  input  logic [WORD_W-1:0]  mem_rd_data,
  input  logic               mem_rd_last,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]        perf_access_o,
  output logic [31:0]        perf_miss_o,
`endif
  output logic [2:0]         dbg_state
);

  icr_state_t          state_q, state_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]    ptag_q, ptag_d;
  logic                unc_q, unc_d;
  logic                drop_q, drop_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LINE_W-1:0]   buf_q, buf_d;

  logic                rd_en, wr_en;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_data;
  logic                hit;
  logic                accept;
  logic                miss_evt;

  logic unused_inputs;
  assign unused_inputs = ^{inst_wr, inst_size, inst_wdata};

  icache_line_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_index (inst_index),
    .wr_en    (wr_en),
    .wr_index (idx_q),
    .wr_tag   (ptag_q),
    .wr_data  (buf_d),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  assign hit       = rd_valid && (rd_tag == inst_ptag_i) && !inst_uncached_i;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ICR_IDLE;
      idx_q   <= '0;
      ptag_q  <= '0;
      unc_q   <= 1'b0;
      drop_q  <= 1'b0;
      beat_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptag_q  <= ptag_d;
      unc_q   <= unc_d;
      drop_q  <= drop_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ptag_d        = ptag_q;
    unc_d         = unc_q;
    drop_d        = drop_q;
    beat_d        = beat_q;
    buf_d         = buf_q;
    inst_index_ok = 1'b0;
    inst_data_ok  = 1'b0;
    inst_rdata    = '0;
    mem_rd_req    = 1'b0;
    mem_rd_addr   = {ZERO_WORD};
    rd_en         = 1'b0;
    wr_en         = 1'b0;
    accept        = 1'b0;
    miss_evt      = 1'b0;

    unique case (state_q)
      ICR_IDLE: begin
        inst_index_ok = 1'b1;
        drop_d        = 1'b0;
        if (inst_req) begin
          accept  = 1'b1;
          rd_en   = 1'b1;
          idx_d   = inst_index;
          state_d = ICR_LOOKUP;
        end
      end

      ICR_LOOKUP: begin
        if (hit) begin
          // Hits keep the bus open so the next fetch pipelines behind this
          // one; a cancel only kills this response, never the new request.
          inst_index_ok = 1'b1;
          if (!inst_cancel_i) begin
            inst_data_ok = 1'b1;
            inst_rdata   = rd_data;
          end
          if (inst_req) begin
            accept  = 1'b1;
            rd_en   = 1'b1;
            idx_d   = inst_index;
            state_d = ICR_LOOKUP;
          end else begin
            state_d = ICR_IDLE;
          end
        end else begin
          miss_evt = 1'b1;
          if (inst_cancel_i) begin
            state_d = ICR_IDLE;
          end else begin
            ptag_d  = inst_ptag_i;
            unc_d   = inst_uncached_i;
            state_d = ICR_MISS_REQ;
          end
        end
      end

      ICR_MISS_REQ: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {ptag_q, idx_q, {OFFSET_W{1'b0}}};
        beat_d      = '0;
        if (inst_cancel_i) drop_d = 1'b1;
        if (mem_rd_ready) state_d = ICR_REFILL;
      end

      ICR_REFILL: begin
        // A cancelled burst still runs to completion so memory sees a
        // well-formed transaction and cached lines still get filled.
        if (inst_cancel_i) drop_d = 1'b1;
        if (mem_rd_valid) begin
          buf_d[{beat_q, 5'd0} +: WORD_W] = mem_rd_data;
          beat_d = beat_q + 1'b1;
          if (mem_rd_last) begin
            wr_en   = !unc_q;
            state_d = ICR_RESP;
          end
        end
      end

      ICR_RESP: begin
        if (!drop_q && !inst_cancel_i) begin
          inst_data_ok = 1'b1;
          inst_rdata   = buf_q;
        end
        drop_d  = 1'b0;
        state_d = ICR_IDLE;
      end

      default: begin
        state_d = ICR_IDLE;
      end
    endcase
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_access_o <= '0;
      perf_miss_o   <= '0;
    end else begin
      if (accept)   perf_access_o <= perf_access_o + 32'd1;
      if (miss_evt) perf_miss_o   <= perf_miss_o + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = accept ^ miss_evt;
`endif

endmodule
